// File: rtl/hash_result_pkg.sv
// Shared types for the hash table result path: status codes, flag bundle
// and the priority encoder that folds table flags into a single code.
package hash_result_pkg;

    typedef enum logic [2:0] {
        ST_OK        = 3'd0,
        ST_NOT_FOUND = 3'd1,
        ST_NO_TARGET = 3'd2,
        ST_NO_SPACE  = 3'd3,
        ST_DUPLICATE = 3'd4
    } ht_status_e;

    localparam int STATUS_W = $bits(ht_status_e);

    typedef struct packed {
        logic key_already_present;
        logic no_write_space;
        logic no_deletion_target;
        logic no_element_found;
    } ht_flags_t;

    // Several flags can be raised together; the most severe one wins.
    function automatic ht_status_e encode_status(input ht_flags_t flags);
        if (flags.key_already_present) return ST_DUPLICATE;
        if (flags.no_write_space)      return ST_NO_SPACE;
        if (flags.no_deletion_target)  return ST_NO_TARGET;
        if (flags.no_element_found)    return ST_NOT_FOUND;
        return ST_OK;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy. Caller guarantees no push
// when full and no pop when empty.
module sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is not reset; the consumer masks the head while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/hash_result_buffer.sv
// Result buffer behind the hash table: queues completed operations, encodes
// their status, back-pressures the table and keeps saturating statistics.
module hash_result_buffer import hash_result_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ht_valid_i,
    input  logic [DATA_WIDTH-1:0]         ht_read_data_i,
    input  logic                          ht_no_deletion_target_i,
    input  logic                          ht_no_write_space_i,
    input  logic                          ht_no_element_found_i,
    input  logic                          ht_key_already_present_i,
    output logic                          ht_ready_o,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [DATA_WIDTH-1:0]         res_data_o,
    output logic [2:0]                    res_status_o,
    output logic [$clog2(FIFO_DEPTH):0]   res_count_o,
    input  logic                          clear_stats_i,
    output logic [STAT_WIDTH-1:0]         stat_ops_o,
    output logic [STAT_WIDTH-1:0]         stat_err_o
);
    localparam int EW = DATA_WIDTH + STATUS_W;

    ht_flags_t  flags;
    ht_status_e push_status;
    ht_status_e head_status;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [EW-1:0] fifo_din;
    logic [EW-1:0] fifo_dout;

    assign flags = '{
        key_already_present: ht_key_already_present_i,
        no_write_space:      ht_no_write_space_i,
        no_deletion_target:  ht_no_deletion_target_i,
        no_element_found:    ht_no_element_found_i
    };
    assign push_status = encode_status(flags);

    // Ready comes from registered occupancy only, so a full buffer with a
    // pop costs one bubble instead of a ready->valid combinational loop.
    assign ht_ready_o  = ~full;
    assign res_valid_o = ~empty;
    assign push        = ht_valid_i & ht_ready_o;
    assign pop         = res_valid_o & res_ready_i;
    assign fifo_din    = {push_status, ht_read_data_i};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (res_count_o),
        .full  (full),
        .empty (empty)
    );

    assign head_status  = ht_status_e'(fifo_dout[DATA_WIDTH +: STATUS_W]);
    assign res_data_o   = empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
    assign res_status_o = empty ? ST_OK : head_status;

    always_ff @(posedge clk) begin
        if (reset || clear_stats_i) begin
            stat_ops_o <= '0;
            stat_err_o <= '0;
        end else if (push) begin
            if (stat_ops_o != '1) stat_ops_o <= stat_ops_o + 1'b1;
            if (push_status != ST_OK && stat_err_o != '1) stat_err_o <= stat_err_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_hash_result_buffer.sv
// Scenario bench for hash_result_buffer: scoreboard of accepted results
// checked in order as the consumer pops them, plus per-scenario checks.
module tb_hash_result_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ht_valid_i = 1'b0;
    logic [DW-1:0] ht_read_data_i = '0;
    logic          ht_no_deletion_target_i = 1'b0;
    logic          ht_no_write_space_i = 1'b0;
    logic          ht_no_element_found_i = 1'b0;
    logic          ht_key_already_present_i = 1'b0;
    logic          ht_ready_o;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic [DW-1:0] res_data_o;
    logic [2:0]    res_status_o;
    logic [2:0]    res_count_o;
    logic          clear_stats_i = 1'b0;
    logic [SW-1:0] stat_ops_o;
    logic [SW-1:0] stat_err_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [2:0]    status;
    } exp_t;
    exp_t q[$];
    logic [SW-1:0] exp_ops = '0;
    logic [SW-1:0] exp_err = '0;

    hash_result_buffer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STAT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .ht_valid_i(ht_valid_i), .ht_read_data_i(ht_read_data_i),
        .ht_no_deletion_target_i(ht_no_deletion_target_i), .ht_no_write_space_i(ht_no_write_space_i),
        .ht_no_element_found_i(ht_no_element_found_i), .ht_key_already_present_i(ht_key_already_present_i),
        .ht_ready_o(ht_ready_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_status_o(res_status_o), .res_count_o(res_count_o),
        .clear_stats_i(clear_stats_i), .stat_ops_o(stat_ops_o), .stat_err_o(stat_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_status(input logic kap, input logic nws, input logic ndt, input logic nef);
        if (kap) return 3'd4;
        if (nws) return 3'd3;
        if (ndt) return 3'd2;
        if (nef) return 3'd1;
        return 3'd0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // f = {key_already_present, no_write_space, no_deletion_target, no_element_found}
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [3:0] f);
        ht_valid_i     = v;
        ht_read_data_i = d;
        {ht_key_already_present_i, ht_no_write_space_i, ht_no_deletion_target_i, ht_no_element_found_i} = f;
    endtask

    // Runs at the falling edge: inputs and outputs are stable for the next rising edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
                exp_ops = '0;
                exp_err = '0;
            end else begin
                checks++;
                if (ht_ready_o !== (q.size() != DEPTH)) begin errors++; $display("FAIL mon_ready: got %b want %b", ht_ready_o, q.size() != DEPTH); end
                checks++;
                if (res_valid_o !== (q.size() != 0)) begin errors++; $display("FAIL mon_valid: got %b want %b", res_valid_o, q.size() != 0); end
                if (q.size() == 0) begin
                    checks++;
                    if (res_data_o !== '0 || res_status_o !== 3'd0) begin errors++; $display("FAIL mon_mask: got data %h status %0d want 0 0", res_data_o, res_status_o); end
                end
                if (res_valid_o && res_ready_i) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++; $display("FAIL mon_pop_empty: got pop with data %h want no entry", res_data_o);
                    end else begin
                        e = q.pop_front();
                        if (res_data_o !== e.data || res_status_o !== e.status) begin
                            errors++; $display("FAIL mon_order: got %h/%0d want %h/%0d", res_data_o, res_status_o, e.data, e.status);
                        end
                    end
                end
                if (ht_valid_i && ht_ready_o) begin
                    e.data   = ht_read_data_i;
                    e.status = exp_status(ht_key_already_present_i, ht_no_write_space_i, ht_no_deletion_target_i, ht_no_element_found_i);
                    q.push_back(e);
                end
                if (clear_stats_i) begin
                    exp_ops = '0;
                    exp_err = '0;
                end else if (ht_valid_i && ht_ready_o) begin
                    if (exp_ops != '1) exp_ops = exp_ops + 1'b1;
                    if (e.status != 3'd0 && exp_err != '1) exp_err = exp_err + 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, 4'b0);
        repeat (2) cyc();
        reset = 1'b0;
        checks++; if (ht_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ht_ready_o); end
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid_o); end
        checks++; if (res_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", res_data_o); end
        checks++; if (res_status_o !== 3'd0) begin errors++; $display("FAIL reset_status: got %0d want 0", res_status_o); end
        checks++; if (res_count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", res_count_o); end
        checks++; if (stat_ops_o !== '0 || stat_err_o !== '0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_ops_o, stat_err_o); end
    endtask

    task automatic test_single();
        res_ready_i = 1'b0;
        drive(1'b1, 32'hDEADBEEF, 4'b0000);
        cyc();
        drive(1'b0, '0, 4'b0);
        checks++; if (res_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", res_valid_o); end
        checks++; if (res_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", res_data_o); end
        checks++; if (res_status_o !== 3'd0) begin errors++; $display("FAIL single_status: got %0d want 0", res_status_o); end
        checks++; if (res_count_o !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", res_count_o); end
        res_ready_i = 1'b1;
        cyc();
        res_ready_i = 1'b0;
        checks++; if (res_count_o !== 3'd0) begin errors++; $display("FAIL single_pop_count: got %0d want 0", res_count_o); end
        checks++; if (stat_ops_o !== 8'd1 || stat_err_o !== 8'd0) begin errors++; $display("FAIL single_stats: got %0d/%0d want 1/0", stat_ops_o, stat_err_o); end
    endtask

    task automatic test_priority();
        res_ready_i = 1'b0;
        drive(1'b1, 32'h11, 4'b1100);
        cyc();
        checks++; if (res_status_o !== 3'd4) begin errors++; $display("FAIL prio_dup_over_space: got %0d want 4", res_status_o); end
        drive(1'b1, 32'h22, 4'b0001);
        cyc();
        checks++; if (stat_err_o !== 8'd2) begin errors++; $display("FAIL prio_err2: got %0d want 2", stat_err_o); end
        drive(1'b1, 32'h33, 4'b0011);
        cyc();
        drive(1'b1, 32'h44, 4'b0110);
        cyc();
        drive(1'b0, '0, 4'b0);
        checks++; if (res_count_o !== 3'd4 || ht_ready_o !== 1'b0) begin errors++; $display("FAIL prio_full: got count %0d ready %b want 4 0", res_count_o, ht_ready_o); end
        res_ready_i = 1'b1;
        repeat (4) cyc();
        res_ready_i = 1'b0;
        checks++; if (stat_ops_o !== 8'd5 || stat_err_o !== 8'd4) begin errors++; $display("FAIL prio_stats: got %0d/%0d want 5/4", stat_ops_o, stat_err_o); end
    endtask

    task automatic test_fill();
        int n;
        res_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 4'b0);
            cyc();
        end
        checks++; if (ht_ready_o !== 1'b0 || res_count_o !== 3'd4) begin errors++; $display("FAIL fill_full: got ready %b count %0d want 0 4", ht_ready_o, res_count_o); end
        drive(1'b1, 32'h104, 4'b0);
        repeat (2) cyc();
        checks++; if (res_count_o !== 3'd4) begin errors++; $display("FAIL fill_held: got %0d want 4", res_count_o); end
        res_ready_i = 1'b1;
        cyc();
        res_ready_i = 1'b0;
        checks++; if (res_count_o !== 3'd3 || ht_ready_o !== 1'b1) begin errors++; $display("FAIL fill_bubble: got count %0d ready %b want 3 1", res_count_o, ht_ready_o); end
        cyc();
        checks++; if (res_count_o !== 3'd4) begin errors++; $display("FAIL fill_fifth: got %0d want 4", res_count_o); end
        res_ready_i = 1'b1;
        for (int k = 5; k < 10; k++) begin
            drive(1'b1, 32'h100 + 32'(k), 4'b0);
            n = 0;
            while (!ht_ready_o && n < 10) begin cyc(); n++; end
            if (n == 10) begin errors++; checks++; $display("FAIL fill_accept_timeout: got ready 0 want 1 within 10 cycles"); end
            cyc();
        end
        drive(1'b0, '0, 4'b0);
        n = 0;
        while (res_valid_o && n < 20) begin cyc(); n++; end
        res_ready_i = 1'b0;
        checks++; if (res_count_o !== 3'd0 || q.size() != 0) begin errors++; $display("FAIL fill_drain: got count %0d pending %0d want 0 0", res_count_o, q.size()); end
    endtask

    task automatic test_back_to_back();
        int n;
        res_ready_i = 1'b0;
        drive(1'b1, 32'h200, 4'b0); cyc();
        drive(1'b1, 32'h201, 4'b0); cyc();
        drive(1'b0, '0, 4'b0);
        clear_stats_i = 1'b1;
        cyc();
        clear_stats_i = 1'b0;
        checks++; if (stat_ops_o !== '0) begin errors++; $display("FAIL b2b_clear: got %0d want 0", stat_ops_o); end
        res_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h300 + 32'(i), 4'(i % 16));
            cyc();
            checks++; if (res_count_o !== 3'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2 at %0d", res_count_o, i); end
        end
        drive(1'b0, '0, 4'b0);
        res_ready_i = 1'b0;
        checks++; if (stat_ops_o !== 8'd20) begin errors++; $display("FAIL b2b_ops: got %0d want 20", stat_ops_o); end
        checks++; if (stat_err_o !== exp_err) begin errors++; $display("FAIL b2b_err: got %0d want %0d", stat_err_o, exp_err); end
        res_ready_i = 1'b1;
        n = 0;
        while (res_valid_o && n < 10) begin cyc(); n++; end
        res_ready_i = 1'b0;
    endtask

    task automatic test_stats();
        int n;
        clear_stats_i = 1'b1;
        cyc();
        clear_stats_i = 1'b0;
        res_ready_i = 1'b1;
        for (int i = 0; i < (2**SW) - 2; i++) begin
            drive(1'b1, 32'(i), 4'b0001);
            cyc();
        end
        drive(1'b0, '0, 4'b0);
        checks++; if (stat_ops_o !== 8'hFE || stat_err_o !== 8'hFE) begin errors++; $display("FAIL stat_fe: got %h/%h want fe/fe", stat_ops_o, stat_err_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 4'b0001);
            cyc();
        end
        drive(1'b0, '0, 4'b0);
        checks++; if (stat_ops_o !== 8'hFF || stat_err_o !== 8'hFF) begin errors++; $display("FAIL stat_sat: got %h/%h want ff/ff", stat_ops_o, stat_err_o); end
        drive(1'b1, 32'h55, 4'b1000);
        clear_stats_i = 1'b1;
        cyc();
        clear_stats_i = 1'b0;
        drive(1'b0, '0, 4'b0);
        checks++; if (stat_ops_o !== '0 || stat_err_o !== '0) begin errors++; $display("FAIL stat_clear_push: got %0d/%0d want 0/0", stat_ops_o, stat_err_o); end
        n = 0;
        while (res_valid_o && n < 10) begin cyc(); n++; end
        res_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC0 + 32'(i), 4'b0);
            cyc();
        end
        drive(1'b0, '0, 4'b0);
        checks++; if (res_count_o !== 3'd3) begin errors++; $display("FAIL stat_pre_reset: got %0d want 3", res_count_o); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (res_count_o !== 3'd0 || res_valid_o !== 1'b0 || ht_ready_o !== 1'b1) begin
            errors++; $display("FAIL stat_flush: got count %0d valid %b ready %b want 0 0 1", res_count_o, res_valid_o, ht_ready_o);
        end
        drive(1'b1, 32'hABCD, 4'b0);
        cyc();
        drive(1'b0, '0, 4'b0);
        checks++; if (res_data_o !== 32'hABCD || stat_ops_o !== 8'd1) begin errors++; $display("FAIL stat_post_reset: got %h ops %0d want abcd 1", res_data_o, stat_ops_o); end
        res_ready_i = 1'b1;
        cyc();
        res_ready_i = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_priority();
        test_fill();
        test_back_to_back();
        test_stats();
        cyc();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL final_pending: got %0d want 0", q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
